// File: rtl/pipe_pkg.sv
// Shared definitions for the decode-stage hazard controller: NOP optype, register-zero
// address, interrupt FSM encoding and scoreboard slot layout.
package pipe_pkg;

   localparam logic [5:0] OPTYPE_NOP       = 6'h3F;
   localparam logic [4:0] REG_ZERO         = 5'd0;
   localparam int         PIPE_DEPTH_DEF   = 3;
   localparam int         FLUSH_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ENTER = 2'd2,
      ST_ISR   = 2'd3
   } int_state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] addr;
   } sb_slot_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Tracks destination registers of instructions in EX/MEM/WB and flags source matches.
// slot_q[0] is EX; every slot shifts one stage per cycle.
module reg_scoreboard
   import pipe_pkg::*;
#(
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [4:0] addr,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       uses_rs,
   input  logic       uses_rt,
   output logic       hit_rs,
   output logic       hit_rt,
   output logic       busy
);

   sb_slot_t slot_q [PIPE_DEPTH];
   sb_slot_t slot_d [PIPE_DEPTH];

   always_comb begin
      slot_d[0].valid = push;
      slot_d[0].addr  = push ? addr : REG_ZERO;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         slot_d[k] = slot_q[k-1];
      end
   end

   // NOTE: the slot array is reset explicitly; a stale valid bit after reset would stall decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         slot_q <= slot_d;
      end
   end

   // The last slot still counts: the regfile write lands at the end of WB, with no write-through.
   always_comb begin
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      busy   = 1'b0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         busy = busy | slot_q[k].valid;
         if (slot_q[k].valid && slot_q[k].addr == rs) hit_rs = 1'b1;
         if (slot_q[k].valid && slot_q[k].addr == rt) hit_rt = 1'b1;
      end
      hit_rs = hit_rs & uses_rs & (rs != REG_ZERO);
      hit_rt = hit_rt & uses_rt & (rt != REG_ZERO);
   end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Stage-2 hazard controller: RAW stalls from the scoreboard, flush bubbles after EX
// redirects, and the interrupt drain/enter/eret sequence.
module decode_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int PIPE_DEPTH   = PIPE_DEPTH_DEF,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] id_rd,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       id_eret,
   input  logic       ex_redirect,
   input  logic       int_req,
   output logic       ir_stall,
   output logic       ir_bubble,
   output logic       is_int,
   output logic       int_ack,
   output logic       in_isr,
   output logic       sb_busy
);

   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   int_state_e    state_q, state_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic          hit_rs, hit_rt, hazard, flushing, push;

   assign hazard   = hit_rs | hit_rt;
   assign flushing = ex_redirect | (flush_cnt_q != '0);
   assign push     = id_valid & (id_rd != REG_ZERO) & ~ir_stall & ~ir_bubble;

   reg_scoreboard #(
      .PIPE_DEPTH(PIPE_DEPTH)
   ) u_sb (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .addr   (id_rd),
      .rs     (id_rs),
      .rt     (id_rt),
      .uses_rs(id_uses_rs),
      .uses_rt(id_uses_rt),
      .hit_rs (hit_rs),
      .hit_rt (hit_rt),
      .busy   (sb_busy)
   );

   // NOTE: every output and next-state term gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ir_stall  = 1'b0;
      ir_bubble = 1'b0;
      is_int    = 1'b0;
      int_ack   = 1'b0;
      in_isr    = 1'b0;

      if (flushing || state_q == ST_DRAIN || state_q == ST_ENTER) begin
         ir_bubble = 1'b1;
      end else if (hazard) begin
         ir_stall = 1'b1;
      end

      unique case (state_q)
         ST_RUN: begin
            if (int_req && !ex_redirect && flush_cnt_q == '0) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!sb_busy && !ex_redirect) state_d = ST_ENTER;
         end
         ST_ENTER: begin
            is_int  = 1'b1;
            int_ack = 1'b1;
            state_d = ST_ISR;
         end
         ST_ISR: begin
            in_isr = 1'b1;
            if (id_eret && !ir_stall) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (ex_redirect) begin
         flush_cnt_d = FW'(FLUSH_CYCLES - 1);
      end else if (flush_cnt_q != '0) begin
         flush_cnt_d = flush_cnt_q - FW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: a timestamp-based reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_decode_hazard_ctrl;

   localparam int DEPTH = 3;
   localparam int FLUSH = 2;
   localparam int M_RUN = 0, M_DRAIN = 1, M_ENTER = 2, M_ISR = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_uses_rs, id_uses_rt, id_eret, ex_redirect, int_req;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ir_stall, ir_bubble, is_int, int_ack, in_isr, sb_busy;

   always #5 clk = ~clk;

   decode_hazard_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rd      (id_rd),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .id_eret    (id_eret),
      .ex_redirect(ex_redirect),
      .int_req    (int_req),
      .ir_stall   (ir_stall),
      .ir_bubble  (ir_bubble),
      .is_int     (is_int),
      .int_ack    (int_ack),
      .in_isr     (in_isr),
      .sb_busy    (sb_busy)
   );

   int checks   = 0;
   int failures = 0;

   logic [5:0] exp_q [$];
   int         exp_cyc_q [$];

   // Reference model: writes are remembered with the cycle they issued and stay visible
   // for DEPTH cycles; a redirect bubbles FLUSH cycles starting with its own.
   int push_rd [$];
   int push_t  [$];
   int cyc;
   int last_redir;
   int mode;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got {stall,bubble,is_int,ack,in_isr,busy}=%b expected %b", name, act, req);
      end
   endtask

   function automatic logic [5:0] observe();
      return {ir_stall, ir_bubble, is_int, int_ack, in_isr, sb_busy};
   endfunction

   function automatic bit pending(input int r, input bit any);
      for (int i = 0; i < push_rd.size(); i++) begin
         if (push_t[i] >= cyc - DEPTH && push_t[i] <= cyc - 1 && (any || push_rd[i] == r))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic reset_model();
      push_rd.delete();
      push_t.delete();
      last_redir = cyc - 1000;
      mode       = M_RUN;
   endtask

   task automatic drive_idle();
      id_valid = 0; id_rd = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_eret = 0; ex_redirect = 0; int_req = 0;
   endtask

   task automatic step(input bit v, input int rd, input int rs, input int rt, input bit urs,
                       input bit urt, input bit eret, input bit redir, input bit irq);
      bit hz, busy, flush, bub, stl;
      @(posedge clk);
      #1;
      id_valid = v; id_rd = 5'(rd); id_rs = 5'(rs); id_rt = 5'(rt);
      id_uses_rs = urs; id_uses_rt = urt; id_eret = eret; ex_redirect = redir; int_req = irq;

      while (push_t.size() > 0 && push_t[0] < cyc - DEPTH) begin
         void'(push_t.pop_front());
         void'(push_rd.pop_front());
      end
      hz    = (urs && rs != 0 && pending(rs, 0)) || (urt && rt != 0 && pending(rt, 0));
      busy  = pending(0, 1);
      flush = redir || (cyc - last_redir) < FLUSH;
      bub   = flush || mode == M_DRAIN || mode == M_ENTER;
      stl   = !bub && hz;
      exp_q.push_back({stl, bub, mode == M_ENTER, mode == M_ENTER, mode == M_ISR, busy});
      exp_cyc_q.push_back(cyc);

      if (v && rd != 0 && !stl && !bub) begin
         push_rd.push_back(rd);
         push_t.push_back(cyc);
      end
      case (mode)
         M_RUN:   if (irq && !redir && (cyc - last_redir) >= FLUSH) mode = M_DRAIN;
         M_DRAIN: if (!busy && !redir) mode = M_ENTER;
         M_ENTER: mode = M_ISR;
         default: if (eret && !stl) mode = M_RUN;
      endcase
      if (redir) last_redir = cyc;
      cyc++;
   endtask

   task automatic idle(input int n, input bit irq);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, irq);
   endtask

   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         logic [5:0] e;
         int         c;
         e = exp_q.pop_front();
         c = exp_cyc_q.pop_front();
         check($sformatf("cycle%0d", c), observe(), e);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0;
      reset_model();
      drive_idle();
      rst_n = 1'b0;
      #2;
      check("reset_state", observe(), 6'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // RAW: three stall cycles, then the held instruction issues
      step(1, 8, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) step(1, 9, 8, 0, 1, 0, 0, 0, 0);
      idle(4, 0);

      // $0 never hazards
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 1, 0, 0, 0);
      idle(3, 0);

      // redirect over a live hazard
      step(1, 10, 0, 0, 0, 0, 0, 0, 0);
      step(1, 2, 10, 0, 1, 0, 0, 1, 0);
      step(1, 2, 10, 0, 1, 0, 0, 0, 0);
      idle(4, 0);

      // interrupt entry with two writes in flight, masked re-request, eret
      step(1, 11, 0, 0, 0, 0, 0, 0, 0);
      step(1, 12, 0, 0, 0, 0, 0, 0, 1);
      idle(6, 1);
      repeat (3) step(1, 3, 1, 2, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(3, 0);

      // redirect one cycle into DRAIN
      step(1, 13, 0, 0, 0, 0, 0, 0, 0);
      step(1, 14, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(6, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(3, 0);

      // async reset mid-DRAIN with slots valid
      step(1, 15, 0, 0, 0, 0, 0, 0, 0);
      step(1, 16, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      #2;
      drive_idle();
      rst_n = 1'b0;
      #1;
      check("async_reset", observe(), 6'b0);
      reset_model();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      idle(2, 0);

      // randomized traffic
      begin
         bit irq = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) irq = !irq;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10, irq);
         end
      end
      drive_idle();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Hazard and sequencing controller for the decode/register-read stage (stage 2) of the 5-stage MIPS pipeline.
- Drives that stage's `ir_stall` / `ir_bubble` / `is_int` inputs:
  - stalls on read-after-write (RAW) hazards against in-flight register writes (no forwarding; the regfile is written in stage 5);
  - inserts flush bubbles on EX-stage redirects;
  - sequences interrupt entry (drain, then enter) and `eret` return.

Parameters:
- PIPE_DEPTH, 3, number of in-flight stages after decode (EX, MEM, WB) tracked by the scoreboard.
- FLUSH_CYCLES, 2, bubbles inserted after a redirect.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a real instruction (not nop/bubble)
- id_rs  in  5  source register 1 address
- id_rt  in  5  source register 2 address
- id_rd  in  5  destination register address (0 = no write)
- id_uses_rs  in  1  instruction reads id_rs
- id_uses_rt  in  1  instruction reads id_rt
- id_eret  in  1  decode holds eret (decode's RTI)
- ex_redirect  in  1  branch taken / jump / jr resolved in EX this cycle
- int_req  in  1  level interrupt request
- ir_stall  out  1  hold decode and fetch
- ir_bubble  out  1  replace decode output with nop (optype 3F)
- is_int  out  1  one-cycle interrupt entry pulse to decode
- int_ack  out  1  same cycle as is_int, to the interrupt source
- in_isr  out  1  handler running, further int_req masked
- sb_busy  out  1  any scoreboard slot valid

Behaviour:
- Scoreboard:
  - slot[0..PIPE_DEPTH-1] = {valid, addr}; slot[0] = EX.
  - Every cycle, slot[k] <= slot[k-1].
  - slot[0] loads {1, id_rd} when id_valid, id_rd != 0, and neither ir_stall nor ir_bubble is asserted; otherwise slot[0] loads invalid.
- Hazard:
  - `hazard` = (id_uses_rs, id_rs != 0, and id_rs matches a valid slot) OR (same check for rt).
  - The last slot counts as a hazard: the regfile has no write-through.
- Output priority (combinational, from registered state): redirect/flush > DRAIN/ENTER > hazard.
  - ex_redirect, or flush_cnt != 0: ir_bubble=1, ir_stall=0.
  - State DRAIN: ir_bubble=1.
  - Else hazard: ir_stall=1, ir_bubble=0.
- Flush counter:
  - On ex_redirect, flush_cnt <= FLUSH_CYCLES-1.
  - Decrements to 0; a new redirect reloads it.
- Interrupt FSM, states RUN, DRAIN, ENTER, ISR:
  - RUN -> DRAIN: int_req=1, not in_isr, no redirect and flush_cnt=0 this cycle.
  - DRAIN: bubbles; stays while sb_busy or ex_redirect. DRAIN -> ENTER when the scoreboard is empty.
  - ENTER (1 cycle): is_int=1, int_ack=1, ir_bubble=1. ENTER -> ISR.
  - ISR: normal hazard/flush handling, in_isr=1, int_req ignored. ISR -> RUN when id_eret and not ir_stall.
  - id_eret in RUN: ignored.
- Simultaneous events:
  - ex_redirect during DRAIN: the redirect is honoured (flush loaded); DRAIN continues.
  - Hazard and redirect in the same cycle: bubble wins, no stall.
- Reset (async, any time, including mid-DRAIN or mid-flush):
  - all slots invalid, flush_cnt=0, state RUN.
  - ir_stall=0, ir_bubble=0, is_int=0, int_ack=0, in_isr=0, sb_busy=0.
- Latency: hazard to stall is combinational, same cycle. Stall releases in the cycle after the producing instruction leaves the last slot.

Decomposition:
- Shared package `pipe_pkg`:
  - OPTYPE_NOP=6'h3F, REG_ZERO=5'd0;
  - FSM state encoding (RUN=0, DRAIN=1, ENTER=2, ISR=3);
  - PIPE_DEPTH default.
- Sub-module `reg_scoreboard`: the slot shift register plus match logic (inputs: push, addr, rs, rt, uses; outputs: hit_rs, hit_rt, busy). The FSM and flush counter stay in the top.

Test Plan:
- RAW stall:
  - stimulus: id_rd=8 issued, then next instruction id_rs=8 uses_rs=1;
  - required: ir_stall=1 for exactly 3 cycles, then 0; slot pushes are invalid while stalled.
- No hazard on $0:
  - stimulus: id_rd=0 issued, then id_rs=0;
  - required: ir_stall never asserts.
- Redirect priority:
  - stimulus: ex_redirect pulse while hazard=1;
  - required: ir_bubble=1 for 2 cycles, ir_stall=0 in the redirect cycle.
- Interrupt entry:
  - stimulus: int_req with 2 writes in flight;
  - required: bubbles until sb_busy=0, then is_int=int_ack=1 for one cycle, then in_isr=1; a second int_req is ignored until id_eret, after which in_isr returns to 0.
- Redirect during DRAIN:
  - stimulus: ex_redirect one cycle after entering DRAIN;
  - required: flush_cnt reloads; is_int asserts only after the scoreboard is empty.
- Async reset:
  - stimulus: rst_n low mid-DRAIN with slots valid;
  - required: all outputs 0 immediately, state RUN, sb_busy=0 after release.
